// File: rtl/clock_time_reg.sv
// BCD time-of-day register with a hold-to-set state machine.
// The set rate starts slow and switches to fast after a sustained hold.
module clock_time_reg (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_1hz_stb,
  input  logic       i_slow_set_stb,
  input  logic       i_fast_set_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [5:0] o_hours,
  output logic [6:0] o_minutes,
  output logic [6:0] o_seconds,
  output logic       o_update_stb,
  output logic       o_setting
);

  typedef enum logic [1:0] {
    RUN,
    SET_SLOW,
    SET_FAST
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] hold;
  logic [2:0] hold_nx;
  logic       field;
  logic       field_nx;
  logic [5:0] hrs_nx;
  logic [6:0] min_nx;
  logic [6:0] sec_nx;
  logic       upd_nx;
  logic       inc;
  logic       tick;
  logic       any_set;
  logic       want_hrs;

  // Compares use >= so a digit can never run past its legal range.
  function automatic logic [6:0] inc_60(input logic [6:0] v);
    if (v[6:4] >= 3'd5 && v[3:0] >= 4'd9)
      return 7'd0;
    else if (v[3:0] >= 4'd9)
      return {v[6:4] + 3'd1, 4'd0};
    else
      return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] inc_24(input logic [5:0] v);
    if (v[5:4] >= 2'd2 && v[3:0] >= 4'd3)
      return 6'd0;
    else if (v[3:0] >= 4'd9)
      return {v[5:4] + 2'd1, 4'd0};
    else
      return {v[5:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic is_59(input logic [6:0] v);
    return (v[6:4] >= 3'd5) && (v[3:0] >= 4'd9);
  endfunction

  assign any_set  = i_set_hours | i_set_minutes;
  assign want_hrs = i_set_hours;

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    field_nx = field;
    inc      = 1'b0;
    tick     = 1'b0;
    unique case (state)
      RUN: begin
        if (any_set) begin
          state_nx = SET_SLOW;
          hold_nx  = 3'd0;
          field_nx = want_hrs;
          inc      = 1'b1;
        end else if (i_1hz_stb) begin
          tick = 1'b1;
        end
      end
      SET_SLOW, SET_FAST: begin
        if (!any_set) begin
          state_nx = RUN;
        end else if (want_hrs != field) begin
          state_nx = SET_SLOW;
          hold_nx  = 3'd0;
          field_nx = want_hrs;
          inc      = 1'b1;
        end else if (state == SET_SLOW) begin
          if (i_slow_set_stb) begin
            inc     = 1'b1;
            hold_nx = hold + 3'd1;
            if (hold == 3'd3)
              state_nx = SET_FAST;
          end
        end else if (i_fast_set_stb) begin
          inc = 1'b1;
        end
      end
      default: begin
        state_nx = RUN;
        hold_nx  = 3'd0;
      end
    endcase
  end

  // Set increments wrap in-field; only the 1 Hz tick carries.
  always_comb begin
    hrs_nx = o_hours;
    min_nx = o_minutes;
    sec_nx = o_seconds;
    unique case (1'b1)
      inc: begin
        if (want_hrs) begin
          hrs_nx = inc_24(o_hours);
        end else begin
          min_nx = inc_60(o_minutes);
          sec_nx = 7'd0;
        end
      end
      tick: begin
        sec_nx = inc_60(o_seconds);
        if (is_59(o_seconds)) begin
          min_nx = inc_60(o_minutes);
          if (is_59(o_minutes))
            hrs_nx = inc_24(o_hours);
        end
      end
      default: ;
    endcase
    upd_nx = {hrs_nx, min_nx, sec_nx} !=
             {o_hours, o_minutes, o_seconds};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= RUN;
      hold         <= 3'd0;
      field        <= 1'b0;
      o_hours      <= 6'd0;
      o_minutes    <= 7'd0;
      o_seconds    <= 7'd0;
      o_update_stb <= 1'b0;
      o_setting    <= 1'b0;
    end else begin
      state        <= state_nx;
      hold         <= hold_nx;
      field        <= field_nx;
      o_hours      <= hrs_nx;
      o_minutes    <= min_nx;
      o_seconds    <= sec_nx;
      o_update_stb <= upd_nx;
      o_setting    <= (state_nx != RUN);
    end
  end

endmodule

// File: doc/clock_time_reg.md
CLOCK_TIME_REG -- requirements
Module: clock_time_reg

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, input, 1, system clock; all state updates on the rising edge.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_1hz_stb, input, 1, one-clock strobe at 1 Hz; advances time.
- i_slow_set_stb, input, 1, one-clock strobe at 2 Hz; slow set-rate increment.
- i_fast_set_stb, input, 1, one-clock strobe at 8 Hz; fast set-rate increment.
- i_set_hours, input, 1, debounced level; high while the hours-set button is held.
- i_set_minutes, input, 1, debounced level; high while the minutes-set button is held.
- o_hours, output, 6, BCD hours: [5:4] tens (0-2), [3:0] ones.
- o_minutes, output, 7, BCD minutes: [6:4] tens (0-5), [3:0] ones.
- o_seconds, output, 7, BCD seconds: [6:4] tens (0-5), [3:0] ones.
- o_update_stb, output, 1, one-clock pulse whenever any time output changes value.
- o_setting, output, 1, high whenever the state is not RUN.
REQ-002 The block SHALL use one clock. Reset SHALL be asynchronous and active-low.

Function
REQ-003 The state machine SHALL have three states: RUN, SET_SLOW and SET_FAST.
REQ-004 The active set field SHALL be hours if i_set_hours=1. It SHALL be minutes if i_set_hours=0 and i_set_minutes=1. Hours take priority when both inputs are high.
REQ-005 RUN to SET_SLOW:
- Happens on the first rising edge where the state is RUN and either set input is sampled high.
- On that same edge, the active field SHALL increment once.
- On that same edge, the hold counter SHALL clear to 0.
REQ-006 In SET_SLOW:
- Each i_slow_set_stb SHALL increment the active field.
- Each i_slow_set_stb SHALL increment the 3-bit hold counter.
- On the edge consuming the 4th slow strobe (hold counter reaching 4), the state SHALL go to SET_FAST.
REQ-007 In SET_FAST, each i_fast_set_stb SHALL increment the active field. i_slow_set_stb SHALL be ignored.
REQ-008 From SET_SLOW or SET_FAST, when both set inputs are sampled low:
- The state SHALL return to RUN.
- No increment SHALL occur on that edge, even if a set strobe is present.
REQ-009 If the active field changes mid-set (for example hours released while minutes is still held):
- The state SHALL go to SET_SLOW.
- The hold counter SHALL clear.
- The new field SHALL increment once on that edge.
REQ-010 Set increments SHALL wrap within the field with no carry:
- Minutes 59 -> 00, with hours unchanged.
- Hours 23 -> 00.
REQ-011 Each set increment of minutes SHALL also clear seconds to 00. Setting hours SHALL leave seconds unchanged.
REQ-012 In SET_SLOW and SET_FAST, i_1hz_stb SHALL be ignored and time SHALL NOT advance.
REQ-013 In RUN, each i_1hz_stb SHALL advance time by one second with BCD carry:
- Seconds 59 -> 00 carries into minutes.
- Minutes 59 -> 00 carries into hours.
- 23:59:59 -> 00:00:00.
REQ-014 If i_1hz_stb and a set-input rising condition coincide in RUN, the set entry SHALL win. That i_1hz_stb SHALL be dropped.
REQ-015 All outputs SHALL be registered. A new time value SHALL be visible the cycle after the triggering edge. Input to output latency SHALL be 1 clock.
REQ-016 o_update_stb SHALL be high for exactly the one cycle in which a new time value first appears. It SHALL be low in all other cycles, including strobes that cause no change.
REQ-017 o_setting SHALL be 1 in SET_SLOW and SET_FAST, and 0 in RUN.
REQ-018 Every BCD digit SHALL remain within its legal range at all times. No illegal code such as hours 24 or minutes 60 SHALL ever be output.

Reset
REQ-019 While i_reset_n=0, the block SHALL immediately, without waiting for a clock:
- force state RUN;
- set hold counter=0;
- set o_hours=00, o_minutes=00, o_seconds=00;
- set o_update_stb=0 and o_setting=0.
REQ-020 Reset asserted mid-set SHALL abort the set and discard any pending increment.
REQ-021 After reset release, the first rising edge SHALL evaluate inputs normally. If a set input is high on that edge, the block SHALL enter SET_SLOW per REQ-005.

Verification
REQ-022 Full rollover:
- Stimulus: load 23:59:58 via set sequences, then apply two i_1hz_stb.
- Required: 23:59:59, then 00:00:00.
- Required: o_update_stb pulses once per strobe.
REQ-023 Slow-to-fast transition:
- Stimulus: from 00:00:00, hold i_set_minutes with slow and fast strobes running.
- Required: minutes=01 on entry; 02-05 on slow strobes 1-4; SET_FAST after the 4th slow strobe; +1 per fast strobe thereafter.
- Required: seconds stay 00 throughout.
REQ-024 Hours wrap without carry:
- Stimulus: at 23:45:30, press and release i_set_hours once.
- Required: 00:45:30.
- Required: o_setting high for the held duration.
REQ-025 Coincident strobe and press:
- Stimulus: assert i_1hz_stb and raise i_set_hours on the same edge at 10:20:30.
- Required: 11:20:30; seconds not advanced.
- Stimulus: then release and apply i_1hz_stb.
- Required: 11:20:31.
REQ-026 Both buttons held:
- Stimulus: assert i_set_hours and i_set_minutes together.
- Required: only hours increment.
- Stimulus: release hours while minutes is still held.
- Required: minutes +1 immediately; hold counter restarts.
REQ-027 Asynchronous reset mid-set:
- Stimulus: drop i_reset_n during SET_FAST between clock edges.
- Required: outputs 00:00:00 and o_setting=0 before the next edge.
- Required: after release, time advances from 00:00:00.
